axi_burst_addr_gen: RTL

//  Sequential AXI burst address generator. Accepts one AW/AR command over a

---
 rtl/axi_burst_addr_gen_pkg.sv | 68 ++++++
 rtl/axi_burst_addr_gen_if.sv | 30 +++
 rtl/axi_burst_addr_gen_beat_next.sv | 38 +++
 rtl/axi_burst_addr_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared types and address/strobe arithmetic for the AXI burst address generator.
// The functions work on wide vectors; callers truncate to their own widths.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1
  } gen_state_e;

  localparam int unsigned BOUNDARY_BITS = 32'd12;
  localparam int unsigned MAX_ADDR_W    = 32'd64;
  localparam int unsigned MAX_STRB_W    = 32'd128;

  typedef logic [MAX_ADDR_W-1:0] addr_t;
  typedef logic [MAX_STRB_W-1:0] strb_t;

  function automatic addr_t next_beat_addr(input addr_t      addr,
                                           input logic [2:0] size,
                                           input logic [7:0] len,
                                           input burst_e     burst,
                                           input logic       align);
    addr_t n_bytes;
    addr_t wrap_mask;
    addr_t nxt;
    n_bytes   = 64'd1 << size;
    wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
    nxt       = addr;
    case (burst)
      BURST_INCR: begin
        if (align) begin
          nxt = (addr & ~(n_bytes - 64'd1)) + n_bytes;
        end else begin
          nxt = addr + n_bytes;
        end
      end
      BURST_WRAP: nxt = (addr & ~wrap_mask) | ((addr + n_bytes) & wrap_mask);
      default:    nxt = addr;
    endcase
    return nxt;
  endfunction

  // Only the low address byte matters: lanes never exceed 128 bytes.
  function automatic strb_t beat_strobe(input logic [7:0]  addr_lo,
                                        input logic [2:0]  size,
                                        input int unsigned data_size);
    strb_t       strb;
    int unsigned n_bytes;
    int unsigned lane_mask;
    int unsigned lo;
    int unsigned hi;
    n_bytes   = 32'd1 << size;
    lane_mask = (32'd1 << data_size) - 32'd1;
    lo        = {24'd0, addr_lo} & lane_mask;
    hi        = ({24'd0, addr_lo} & ~(n_bytes - 32'd1) & lane_mask) + n_bytes;
    for (int unsigned i = 32'd0; i < MAX_STRB_W; i++) begin
      strb[i] = (i >= lo) && (i < hi);
    end
    return strb;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command and beat-descriptor bundle between an AXI slave front end and the generator.
interface axi_burst_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [2:0]              cmd_size;
  logic [1:0]              cmd_burst;
  logic                    beat_valid;
  logic                    beat_ready;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [DATA_WIDTH/8-1:0] beat_strb;
  logic [LEN_WIDTH-1:0]    beat_idx;
  logic                    beat_last;
  logic                    beat_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
  );
endinterface

// File: rtl/axi_burst_addr_gen_beat_next.sv
// Combinational next-beat address and lane strobes, plus the strobe of an incoming first beat.
module axi_beat_next
  import axi_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned ALIGN_ADDR = 1
) (
  input  logic [ADDR_WIDTH-1:0]   i_cur_addr,
  input  logic [2:0]              i_size,
  input  logic [LEN_WIDTH-1:0]    i_len,
  input  burst_e                  i_burst,
  input  logic [ADDR_WIDTH-1:0]   i_first_addr,
  input  logic [2:0]              i_first_size,
  output logic [ADDR_WIDTH-1:0]   o_next_addr,
  output logic [DATA_WIDTH/8-1:0] o_next_strb,
  output logic [DATA_WIDTH/8-1:0] o_first_strb
);
  localparam int unsigned STRB_W    = DATA_WIDTH / 32'd8;
  localparam int unsigned DATA_SIZE = $clog2(STRB_W);
  localparam logic        ALIGN_EN  = (ALIGN_ADDR != 32'd0);

  addr_t w_next_full;
  strb_t w_next_strb_full;
  strb_t w_first_strb_full;
  logic  w_unused;

  assign w_next_full       = next_beat_addr(addr_t'(i_cur_addr), i_size, 8'(i_len), i_burst, ALIGN_EN);
  assign o_next_addr       = w_next_full[ADDR_WIDTH-1:0];
  assign w_next_strb_full  = beat_strobe(o_next_addr[7:0], i_size, DATA_SIZE);
  assign w_first_strb_full = beat_strobe(i_first_addr[7:0], i_first_size, DATA_SIZE);
  assign o_next_strb       = w_next_strb_full[STRB_W-1:0];
  assign o_first_strb      = w_first_strb_full[STRB_W-1:0];

  // The wide helper results are only partly consumed at narrow parameterisations.
  assign w_unused = ^{w_next_full, w_next_strb_full, w_first_strb_full};
endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: accepts one AW/AR command and emits one registered
// descriptor per data beat (address, strobe, index, last, error).
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned ALIGN_ADDR = 1
) (
  input logic                 aclk,
  input logic                 aresetn,
  axi_burst_addr_gen_if.slave bus
);
  localparam int unsigned           STRB_W    = DATA_WIDTH / 32'd8;
  localparam int unsigned           DATA_SIZE = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] A_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] A_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  L_ZERO    = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  L_ONE     = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STRB_W-1:0]     S_ZERO    = {STRB_W{1'b0}};

  gen_state_e            r_state;
  gen_state_e            w_state_nxt;
  logic                  r_ready_en;
  burst_e                r_burst;
  logic [2:0]            r_size;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_err;
  logic                  r_beat_valid;
  logic [ADDR_WIDTH-1:0] r_beat_addr;
  logic [STRB_W-1:0]     r_beat_strb;
  logic [LEN_WIDTH-1:0]  r_beat_idx;
  logic                  r_beat_last;

  logic                  w_beat_hs;
  logic                  w_last_hs;
  logic                  w_cmd_ready;
  logic                  w_cmd_hs;
  burst_e                w_cmd_burst;
  logic [7:0]            w_len8;
  logic [ADDR_WIDTH-1:0] w_nbytes;
  logic [ADDR_WIDTH-1:0] w_total;
  logic [ADDR_WIDTH-1:0] w_start;
  logic [ADDR_WIDTH-1:0] w_last_byte;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [STRB_W-1:0]     w_next_strb;
  logic [STRB_W-1:0]     w_first_strb;

  assign w_beat_hs   = r_beat_valid && bus.beat_ready;
  assign w_last_hs   = w_beat_hs && r_beat_last;
  assign w_cmd_ready = r_ready_en && ((r_state == ST_IDLE) || w_last_hs);
  assign w_cmd_hs    = bus.cmd_valid && w_cmd_ready;

  axi_beat_next #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .ALIGN_ADDR (ALIGN_ADDR)
  ) u_beat_next (
    .i_cur_addr   (r_beat_addr),
    .i_size       (r_size),
    .i_len        (r_len),
    .i_burst      (r_burst),
    .i_first_addr (bus.cmd_addr),
    .i_first_size (bus.cmd_size),
    .o_next_addr  (w_next_addr),
    .o_next_strb  (w_next_strb),
    .o_first_strb (w_first_strb)
  );

  // Legality of the offered command; the INCR check uses the last byte of the final beat.
  always_comb begin
    w_cmd_burst = burst_e'(bus.cmd_burst);
    w_len8      = 8'(bus.cmd_len);
    w_nbytes    = A_ONE << bus.cmd_size;
    w_total     = (ADDR_WIDTH'(bus.cmd_len) + A_ONE) << bus.cmd_size;
    if (ALIGN_ADDR != 32'd0) begin
      w_start = bus.cmd_addr & ~(w_nbytes - A_ONE);
    end else begin
      w_start = bus.cmd_addr;
    end
    w_last_byte = w_start + w_total - A_ONE;
    w_err = (w_cmd_burst == BURST_RSVD)
         || (32'(bus.cmd_size) > DATA_SIZE)
         || ((w_cmd_burst == BURST_WRAP)
             && (!(w_len8 inside {8'd1, 8'd3, 8'd7, 8'd15})
                 || ((bus.cmd_addr & (w_nbytes - A_ONE)) != A_ZERO)))
         || ((w_cmd_burst == BURST_INCR)
             && (w_last_byte[ADDR_WIDTH-1:BOUNDARY_BITS] != bus.cmd_addr[ADDR_WIDTH-1:BOUNDARY_BITS]));
  end

  // Next-state logic: a last beat coinciding with a new command chains straight into it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_last_hs && !w_cmd_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command capture and beat descriptor registers; errored bursts replay the start address.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ready_en   <= 1'b0;
      r_burst      <= BURST_FIXED;
      r_size       <= 3'd0;
      r_len        <= L_ZERO;
      r_err        <= 1'b0;
      r_beat_valid <= 1'b0;
      r_beat_addr  <= A_ZERO;
      r_beat_strb  <= S_ZERO;
      r_beat_idx   <= L_ZERO;
      r_beat_last  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_cmd_hs) begin
        r_burst      <= w_err ? BURST_FIXED : w_cmd_burst;
        r_size       <= bus.cmd_size;
        r_len        <= bus.cmd_len;
        r_err        <= w_err;
        r_beat_valid <= 1'b1;
        r_beat_addr  <= bus.cmd_addr;
        r_beat_strb  <= w_err ? S_ZERO : w_first_strb;
        r_beat_idx   <= L_ZERO;
        r_beat_last  <= (bus.cmd_len == L_ZERO);
      end else if (w_beat_hs) begin
        if (r_beat_last) begin
          r_beat_valid <= 1'b0;
        end else begin
          r_beat_addr <= w_next_addr;
          r_beat_strb <= r_err ? S_ZERO : w_next_strb;
          r_beat_idx  <= r_beat_idx + L_ONE;
          r_beat_last <= ((r_beat_idx + L_ONE) == r_len);
        end
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.beat_valid = r_beat_valid;
  assign bus.beat_addr  = r_beat_addr;
  assign bus.beat_strb  = r_beat_strb;
  assign bus.beat_idx   = r_beat_idx;
  assign bus.beat_last  = r_beat_last;
  assign bus.beat_err   = r_err && r_beat_valid;
endmodule
